// File: rtl/periph_pkg.sv
// Shared types and handshake encodings for the peripheral send arbiter.
package periph_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      RELEASE,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] SEND_IDLE = 2'b00;
   localparam logic [1:0] SEND_REQ  = 2'b01;
   localparam logic [1:0] ACK_IDLE  = 2'b00;
   localparam logic [1:0] ACK_OK    = 2'b01;

   // Next round-robin start position after index idx, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         onehot,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // Scan NUM_REQ positions starting at ptr; the first active request wins.
   always_comb begin
      int cand;
      cand   = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = int'(ptr) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!any && req[cand]) begin
            any          = 1'b1;
            idx          = IDX_W'(cand);
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periph_send_arbiter.sv
// Round-robin arbiter that runs the 4-phase send/ack handshake to one shared
// output peripheral on behalf of the granted requester, with a stall watchdog.
module periph_send_arbiter
   import periph_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_dado,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [NUM_REQ-1:0]        err,
   output logic [DATA_W-1:0]         dado,
   output logic [1:0]                send,
   input  logic [1:0]                ack
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int TCNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

   state_t              state, state_n;
   logic [NUM_REQ-1:0]  gnt_n, done_n, err_n;
   logic [DATA_W-1:0]   dado_n;
   logic [1:0]          send_n;
   logic [IDX_W-1:0]    ptr, ptr_n;
   logic [IDX_W-1:0]    win, win_n;
   logic [TCNT_W-1:0]   tcnt, tcnt_n;
   logic [IDX_W-1:0]    ptr_inc;

   logic [NUM_REQ-1:0]  arb_onehot;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .req    (req),
      .ptr    (ptr),
      .onehot (arb_onehot),
      .idx    (arb_idx),
      .any    (arb_any)
   );

   assign ptr_inc = IDX_W'(rr_next(int'(win), NUM_REQ));

   // State and every output register; reset clears all of them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         done  <= '0;
         err   <= '0;
         dado  <= '0;
         send  <= SEND_IDLE;
         ptr   <= '0;
         win   <= '0;
         tcnt  <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         done  <= done_n;
         err   <= err_n;
         dado  <= dado_n;
         send  <= send_n;
         ptr   <= ptr_n;
         win   <= win_n;
         tcnt  <= tcnt_n;
      end
   end

   // Next-state and next-output logic; done/err default low so they pulse.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      done_n  = '0;
      err_n   = '0;
      dado_n  = dado;
      send_n  = send;
      ptr_n   = ptr;
      win_n   = win;
      tcnt_n  = tcnt;
      case (state)
         IDLE: begin
            gnt_n  = '0;
            send_n = SEND_IDLE;
            tcnt_n = '0;
            // Only grant once the peripheral has dropped its previous ack.
            if (arb_any && ack == ACK_IDLE) begin
               gnt_n   = arb_onehot;
               win_n   = arb_idx;
               dado_n  = req_dado[int'(arb_idx)*DATA_W +: DATA_W];
               send_n  = SEND_REQ;
               state_n = SEND;
            end
         end
         SEND: begin
            if (ack == ACK_OK) begin
               send_n  = SEND_IDLE;
               tcnt_n  = '0;
               state_n = RELEASE;
            end else if (tcnt == TLAST) begin
               send_n  = SEND_IDLE;
               err_n   = gnt;
               ptr_n   = ptr_inc;
               state_n = ERR;
            end else begin
               tcnt_n = tcnt + TCNT_W'(1);
            end
         end
         RELEASE: begin
            send_n = SEND_IDLE;
            if (ack == ACK_IDLE) begin
               done_n  = gnt;
               ptr_n   = ptr_inc;
               state_n = DONE;
            end else if (tcnt == TLAST) begin
               err_n   = gnt;
               ptr_n   = ptr_inc;
               state_n = ERR;
            end else begin
               tcnt_n = tcnt + TCNT_W'(1);
            end
         end
         DONE: begin
            gnt_n   = '0;
            state_n = IDLE;
         end
         ERR: begin
            gnt_n   = '0;
            send_n  = SEND_IDLE;
            state_n = IDLE;
         end
         default: begin
            gnt_n   = '0;
            send_n  = SEND_IDLE;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: doc/periph_send_arbiter.md
Name: periph_send_arbiter

Overview:
Shares one handshaked 16-bit output peripheral between NUM_REQ requesters (CPU cores or DMA) using round-robin arbitration.
Runs the full 4-phase send/ack handshake on the peripheral's dado/send/ack port on behalf of the granted requester.
Returns a one-cycle done or err pulse to that requester.
A watchdog aborts the transaction if the peripheral stalls.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 16, width of the dado bus
TIMEOUT, 16, max cycles spent in one wait state before abort (>=2)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
req  in  NUM_REQ  per-requester request level; held until that requester's done/err
req_dado  in  NUM_REQ*DATA_W  requester data, slice i = [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot; active requester for the whole transaction
done  out  NUM_REQ  one-cycle pulse, transaction completed
err  out  NUM_REQ  one-cycle pulse, transaction aborted by timeout
dado  out  DATA_W  data to peripheral
send  out  2  to peripheral: 2'b00 idle, 2'b01 send
ack  in  2  from peripheral: 2'b00 idle, 2'b01 acknowledged; 2'b1x illegal

Behaviour:
- Reset (sync, active-high, effective at any state including mid-transaction): state=IDLE; gnt, done, err, send=0; dado=0; rr pointer=0; timeout counter=0. Outputs read 0 from the first edge with rst=1.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if any req and ack==2'b00, choose a winner round-robin, starting at pointer and searching upward with wrap. Latch req_dado slice into dado, set gnt one-hot, send=2'b01, go to SEND. If ack!=00, stay in IDLE (peripheral not yet released).
  - SEND: hold send=01 and dado. If ack==01: send=00, go to RELEASE.
  - RELEASE: send=00. If ack==00: go to DONE.
  - DONE: done[winner]=1 for one cycle, gnt held this cycle. Pointer = (winner+1) mod NUM_REQ. Next cycle go to IDLE with gnt=0.
  - ERR: send=00, err[winner]=1 for one cycle, pointer advanced as in DONE. Next cycle go to IDLE.
- Timeout:
  - Counter clears on entry to SEND and to RELEASE, and increments each cycle the exit condition is false.
  - When it reaches TIMEOUT-1 with the condition still false, go to ERR.
  - ack==2'b1x is treated as "condition false" and is therefore caught by the timeout.
- Latency with a 1-cycle registered peripheral:
  - req sampled in IDLE at edge t.
  - send=01 from t+1.
  - ack=01 seen at t+2, send=00 from t+3.
  - ack=00 seen at t+4.
  - done pulse during t+5.
  - IDLE at t+6, so the next grant is issued at edge t+6.
- Data rules:
  - dado is captured only at grant; later changes on req_dado are ignored.
  - dado keeps its last value after the transaction.
- Requester rules:
  - Deasserting req mid-transaction does not abort the transaction.
  - req arriving during SEND/RELEASE/DONE/ERR waits; it is sampled in IDLE only.
- Simultaneous events:
  - Multiple reqs in IDLE → lowest index >= pointer wins, with wrap.
  - Repeated contention alternates fairly.
- gnt, done and err are always one-hot or zero. done and err are never both set.

Decomposition:
- Package periph_pkg:
  - state enum {IDLE, SEND, RELEASE, DONE, ERR};
  - constants SEND_IDLE=2'b00, SEND_REQ=2'b01, ACK_IDLE=2'b00, ACK_OK=2'b01.
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot winner from req and pointer, plus winner index. The FSM, timeout counter and pointer register stay in periph_send_arbiter.

Test Plan:
- Single request: req=2'b01, req_dado[15:0]=16'hBEEF, peripheral model responds in 1 cycle → dado=BEEF and send=01 from t+1, send=00 from t+3, done[0] pulse at t+5, gnt=00 at t+6.
- Contention: req=2'b11 held, data 16'h1111/16'h2222 → transaction order 0,1,0,1; each done on the matching index; dado alternates 1111/2222.
- Pointer wrap: NUM_REQ=4, req=4'b1001 with pointer=3 → requester 3 granted first, then 0.
- Stalled peripheral: ack stuck at 00 after grant → err[granted] pulse after TIMEOUT cycles in SEND; send=00; done never asserted; next request is served normally.
- Peripheral not released: ack forced 01 while in IDLE with req pending → no grant until ack=00, then grant on the next edge.
- Reset mid-operation: rst=1 during SEND → next edge gnt=0, send=00, dado=0, pointer=0; after release, req=2'b10 is granted to requester 1 normally.
